// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters, registered sync/blank decode,
// line/frame strobes and a frame counter. Define VGA_TIMING_PIPE_EN to delay hs/vs/blank_n by one pixel tick.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   FCW      = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  output logic           pix_en,
  output logic [CW-1:0]  hcount,
  output logic [CW-1:0]  vcount,
  output logic           vga_hs,
  output logic           vga_vs,
  output logic           vga_blank_n,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC == 0 || V_SYNC == 0 || CLK_DIV == 0) begin : g_bad_cfg
    $fatal(1, "vga_timing_gen: sync widths and CLK_DIV must be non-zero");
  end

  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic [FCW-1:0] frame_count_q, frame_count_d;
  logic           pix_en_q, pix_en_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic           hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic           tick, h_wrap, v_wrap;
  int             h_n, v_n;

  // Decode looks at the next counter values so sync/blank line up with hcount/vcount in the same clk.
  always_comb begin
    tick          = en && (div_q == DIV_LAST);
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    div_d         = div_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_count_d = frame_count_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    pix_en_d      = tick;
    line_start_d  = tick && h_wrap;
    frame_start_d = tick && h_wrap && v_wrap;
    h_n           = 0;
    v_n           = 0;
    if (en) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      if (h_wrap && v_wrap) begin
        frame_count_d = frame_count_q + 1'b1;
      end
      h_n       = int'(hcount_d);
      v_n       = int'(vcount_d);
      hs_d      = (h_n >= HS_START && h_n < HS_STOP) ? HS_POL : ~HS_POL;
      vs_d      = (v_n >= VS_START && v_n < VS_STOP) ? VS_POL : ~VS_POL;
      blank_n_d = (h_n < H_ACTIVE) && (v_n < V_ACTIVE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_count_q <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b1;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  // Extra pixel-tick stage so sync/blank match a pixel generator that registers RGB once.
  logic hs_p_q, vs_p_q, blank_n_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_p_q      <= ~HS_POL;
      vs_p_q      <= ~VS_POL;
      blank_n_p_q <= 1'b1;
    end else if (tick) begin
      hs_p_q      <= hs_q;
      vs_p_q      <= vs_q;
      blank_n_p_q <= blank_n_q;
    end
  end

  assign vga_hs      = hs_p_q;
  assign vga_vs      = vs_p_q;
  assign vga_blank_n = blank_n_p_q;
`else
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
`endif

  assign pix_en      = pix_en_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations share clk/reset/en; each has a pixel-index reference model
// feeding an expected queue and a negedge monitor that pops on pix_en.
module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic en;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL cfg%0d %s: got %0h, expected %0h at %0t", cfg, name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int   DIV  = (g == 0) ? 2   : (g == 1) ? 1 : 3;
    localparam int   HA   = (g == 0) ? 640 : (g == 1) ? 8 : 10;
    localparam int   HF   = (g == 0) ? 16  : (g == 1) ? 1 : 2;
    localparam int   HSW  = (g == 0) ? 96  : (g == 1) ? 2 : 3;
    localparam int   HB   = (g == 0) ? 48  : (g == 1) ? 1 : 2;
    localparam int   VA   = (g == 0) ? 480 : (g == 1) ? 4 : 5;
    localparam int   VF   = (g == 0) ? 10  : (g == 1) ? 1 : 2;
    localparam int   VSW  = (g == 0) ? 2   : (g == 1) ? 1 : 2;
    localparam int   VB   = (g == 0) ? 33  : (g == 1) ? 1 : 3;
    localparam logic HPOL = (g == 1);
    localparam logic VPOL = (g != 0);
    localparam int   CW   = (g == 0) ? 10  : (g == 1) ? 4 : 5;
    localparam int   FCW  = (g == 0) ? 8   : (g == 1) ? 2 : 3;
    localparam int   HT   = HA + HF + HSW + HB;
    localparam int   VT   = VA + VF + VSW + VB;
    localparam int   W    = 2 * CW + 5 + FCW;
`ifdef VGA_TIMING_PIPE_EN
    localparam bit   PIPE = 1'b1;
`else
    localparam bit   PIPE = 1'b0;
`endif
    localparam logic [W-1:0] RST = {CW'(0), CW'(0), ~HPOL, ~VPOL, 1'b1, 1'b0, 1'b0, FCW'(0)};

    logic           pe, hs, vs, bl, ls, fs;
    logic [CW-1:0]  hc, vc;
    logic [FCW-1:0] fc;
    logic [W-1:0]   act;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   last = RST;
    int             e = 0;

    vga_timing_gen #(
      .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(HPOL), .VS_POL(VPOL), .CW(CW), .FCW(FCW)
    ) dut (
      .clk(clk), .reset(reset), .en(en), .pix_en(pe), .hcount(hc), .vcount(vc),
      .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bl), .line_start(ls), .frame_start(fs),
      .frame_count(fc)
    );

    assign act = {hc, vc, hs, vs, bl, ls, fs, fc};

    // Reference: pixel index p = enabled clocks / DIV; everything else is plain arithmetic on p.
    always @(posedge clk) begin
      int p, h, v, f, dp, dh, dv;
      logic hs_e, vs_e, bl_e;
      if (reset) begin
        e = 0;
        exp_q.delete();
      end else if (en) begin
        e++;
        if (e % DIV == 0) begin
          p    = e / DIV;
          h    = p % HT;
          v    = (p / HT) % VT;
          f    = (p / (HT * VT)) % (1 << FCW);
          dp   = (PIPE && p > 0) ? p - 1 : p;
          dh   = dp % HT;
          dv   = (dp / HT) % VT;
          hs_e = (dh >= HA + HF && dh < HA + HF + HSW) ? HPOL : ~HPOL;
          vs_e = (dv >= VA + VF && dv < VA + VF + VSW) ? VPOL : ~VPOL;
          bl_e = (dh < HA) && (dv < VA);
          exp_q.push_back({CW'(h), CW'(v), hs_e, vs_e, bl_e, (h == 0), (h == 0 && v == 0), FCW'(f)});
        end
      end
    end

    always @(negedge clk) begin
      logic [W-1:0] ev;
      if (reset) last = RST;
      check(g, "pix_en", 64'(pe), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        ev   = exp_q.pop_front();
        last = ev;
        last[FCW+1:FCW] = 2'b00;
      end else begin
        ev = last;
      end
      check(g, "outputs", 64'(act), 64'(ev));
    end

    always @(posedge reset) begin
      #1;
      check(g, "async_reset_outputs", 64'(act), 64'(RST));
      check(g, "async_reset_pix_en", 64'(pe), 64'(0));
    end
  end

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    // Stop mid-divide around hcount 300 of the default config, then freeze for 37 clocks.
    repeat (601) @(negedge clk);
    en = 1'b0;
    repeat (37) @(negedge clk);
    en = 1'b1;
    repeat (2500) @(negedge clk);
    repeat (3000) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
    end
    en = 1'b1;
    repeat ($urandom_range(50, 400)) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; next generation of the fixed 640x480 sync controller.
- Produces a pixel-enable tick from the system clock, horizontal/vertical counters, sync pulses with programmable polarity, blanking, and line/frame strobes.
- Also keeps a frame counter for animation pacing.
- Sits between the board clock and the pixel generator/animation logic; replaces the separate clock divider plus sync controller pair.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1); 1 gives pix_en permanently high while running
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- CW, 10, counter width; 2^CW must be >= H_TOTAL and >= V_TOTAL
- FCW, 8, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes all timing state
- pix_en  out  1  one-clk pixel tick
- hcount  out  CW  current pixel column, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_blank_n  out  1  high inside the visible area
- line_start  out  1  one-clk strobe on entering hcount=0
- frame_start  out  1  one-clk strobe on entering (0,0)
- frame_count  out  FCW  completed frames, wraps

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Reset (async, active-high):
  - div counter=0, pix_en=0, hcount=0, vcount=0.
  - vga_hs=~HS_POL, vga_vs=~VS_POL, vga_blank_n=1.
  - line_start=0, frame_start=0, frame_count=0.
- Divider:
  - div counts 0..CLK_DIV-1 while en=1.
  - pix_en=1 for exactly one clk when div==CLK_DIV-1, then div returns to 0.
  - CLK_DIV=1: pix_en=en.
- Counters advance only on pix_en:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount at V_TOTAL-1 with an hcount wrap goes to 0.
- Decode (all outputs registered):
  - Outputs are updated in the same clk as the counters and describe the new counter values. There is zero latency between hcount/vcount and their decode.
  - vga_hs=HS_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - vga_vs=VS_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - vga_blank_n=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
- Strobes:
  - line_start=1 for one clk when hcount wraps to 0.
  - frame_start=1 for one clk when both counters wrap to 0; frame_count increments modulo 2^FCW in that same clk.
  - No strobe after reset release; the first frame_start comes after one full frame.
- en=0:
  - Divider, counters, syncs, blank and frame_count hold.
  - pix_en, line_start and frame_start forced 0.
  - Resuming continues from the held div value, with no skipped or duplicated pixel.
- Reset mid-frame: immediate return to reset values regardless of en or the div phase.
- Elaboration check (simulation assertion):
  - Fatal if 2^CW < H_TOTAL or 2^CW < V_TOTAL.
  - Fatal if any sync width or CLK_DIV is 0.

Optional Feature:
- Macro VGA_TIMING_PIPE_EN.
- Defined:
  - vga_hs, vga_vs and vga_blank_n get one extra pixel-tick delay stage, updated on pix_en.
  - This aligns them with a pixel generator that registers RGB once. hcount, vcount and the strobes are not delayed.
  - Reset value of the delay stage: inactive sync levels, blank_n=1.
- Not defined: zero-delay behaviour as above.

Test Plan:
- Reset then release with en=1, defaults -> all reset values as listed; pix_en pulses on every 2nd clk; no frame_start within the first 800*525*2 clks minus 1.
- Defaults, run one line -> vga_hs=0 exactly for hcount 656..751; vga_blank_n=0 from hcount 640; wrap 799->0 raises line_start for 1 clk and vcount 0->1.
- Defaults, run to vcount=524, hcount=799 -> next pix_en gives (0,0), frame_start=1 for 1 clk, frame_count 0->1; vga_vs=0 exactly on lines 490..491.
- en dropped for 37 clks at hcount=300 mid-divide, then re-raised -> counters and outputs frozen, no strobes; pix_en spacing resumes so the total clk count per line is 800*2+37.
- Small config (H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1, CW=4, FCW=2) run 5 frames -> hs high at hcount 9..10, vs high at vcount 5, frame_count sequence 1,2,3,0,1; reset asserted mid-frame returns to reset values asynchronously.
- VGA_TIMING_PIPE_EN defined, defaults -> vga_hs falls one pix_en after hcount reaches 656; blank_n falls one pix_en after hcount=640; hcount timing unchanged.
